vga_timing_pipe: RTL and testbench

- Parametrised successor to the fixed 640x480 timing-plus-output path.
- One block generates display timing for any resolution and sync polarity, and advances on a pixel clock-enable, so it can run from the system clock.
- Delays sync/blanking by a configurable renderer latency and drives registered, blank-forced VGA pins.
- Sits between the clock/enable source and the board VGA pins; the screen renderer consumes sx/sy/de and returns rgb_in.

---
 rtl/vga_timing_pipe.sv | 126 ++++++++++++
 tb/tb_vga_timing_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator advancing on a pixel clock-enable, with a
// renderer-latency delay line for sync/blank and registered, blank-forced pins.
module vga_timing_pipe #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COORD_W    = 10,
  parameter int RENDER_LAT = 0,
  parameter int R_W        = 3,
  parameter int G_W        = 3,
  parameter int B_W        = 2,
  parameter int FRAME_W    = 16
) (
  input  logic                     clk_pix,
  input  logic                     rst,
  input  logic                     pix_ce,
  output logic [COORD_W-1:0]       sx,
  output logic [COORD_W-1:0]       sy,
  output logic                     de,
  output logic                     line_start,
  output logic                     frame_start,
  output logic [FRAME_W-1:0]       frame_count,
  input  logic [R_W+G_W+B_W-1:0]   rgb_in,
  output logic                     vga_hsync,
  output logic                     vga_vsync,
  output logic [R_W-1:0]           vga_r,
  output logic [G_W-1:0]           vga_g,
  output logic [B_W-1:0]           vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int RGB_W   = R_W + G_W + B_W;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic h_wrap;
  logic v_wrap;
  logic hs_act;
  logic vs_act;

  assign h_wrap = (sx == H_LAST);
  assign v_wrap = (sy == V_LAST);

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx          <= '0;
      sy          <= '0;
      frame_count <= '0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        sx <= '0;
        if (v_wrap) begin
          sy          <= '0;
          frame_count <= frame_count + FRAME_W'(1);
        end else begin
          sy <= sy + COORD_W'(1);
        end
      end else begin
        sx <= sx + COORD_W'(1);
      end
    end
  end

  assign de          = (sx < H_ACT_C) && (sy < V_ACT_C);
  assign line_start  = pix_ce && (sx == '0);
  assign frame_start = line_start && (sy == '0);
  assign hs_act      = (sx >= HS_FIRST) && (sx <= HS_LAST);
  assign vs_act      = (sy >= VS_FIRST) && (sy <= VS_LAST);

  // {hs, vs, de}; all-zero is the inactive (blanked, sync deasserted) value
  logic [2:0] raw_ctl;
  logic [2:0] dly_ctl;

  assign raw_ctl = {hs_act, vs_act, de};

  generate
    if (RENDER_LAT == 0) begin : g_direct
      assign dly_ctl = raw_ctl;
    end else begin : g_delay
      logic [2:0] pipe [RENDER_LAT];

      always_ff @(posedge clk_pix) begin
        if (rst) begin
          for (int i = 0; i < RENDER_LAT; i++) pipe[i] <= '0;
        end else if (pix_ce) begin
          pipe[0] <= raw_ctl;
          for (int i = 1; i < RENDER_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly_ctl = pipe[RENDER_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      vga_hsync <= ~HSYNC_POL;
      vga_vsync <= ~VSYNC_POL;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else if (pix_ce) begin
      vga_hsync <= dly_ctl[2] ? HSYNC_POL : ~HSYNC_POL;
      vga_vsync <= dly_ctl[1] ? VSYNC_POL : ~VSYNC_POL;
      vga_r     <= dly_ctl[0] ? rgb_in[RGB_W-1 -: R_W]     : '0;
      vga_g     <= dly_ctl[0] ? rgb_in[G_W+B_W-1 -: G_W]   : '0;
      vga_b     <= dly_ctl[0] ? rgb_in[B_W-1:0]            : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: small 15x8 timing, one zero-latency active-low
// instance and one latency-2 active-high instance driven from shared inputs.
module tb_vga_timing_pipe;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;   // 15
  localparam int VT = VA + VF + VSW + VB;   // 8
  localparam int FT = HT * VT;              // 120
  localparam int CW = 5;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;
  logic [7:0] rgb_in = '0;

  logic [CW-1:0] a_sx, a_sy, b_sx, b_sy;
  logic a_de, a_ls, a_fs, b_de, b_ls, b_fs;
  logic [FW-1:0] a_fc, b_fc;
  logic a_hs, a_vs, b_hs, b_vs;
  logic [2:0] a_r, a_g, b_r, b_g;
  logic [1:0] a_b, b_b;

  always #5 clk = ~clk;

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COORD_W(CW), .RENDER_LAT(0),
    .R_W(3), .G_W(3), .B_W(2), .FRAME_W(FW)
  ) dut_a (
    .clk_pix(clk), .rst(rst), .pix_ce(pix_ce),
    .sx(a_sx), .sy(a_sy), .de(a_de), .line_start(a_ls), .frame_start(a_fs),
    .frame_count(a_fc), .rgb_in(rgb_in),
    .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
  );

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_W(CW), .RENDER_LAT(2),
    .R_W(3), .G_W(3), .B_W(2), .FRAME_W(FW)
  ) dut_b (
    .clk_pix(clk), .rst(rst), .pix_ce(pix_ce),
    .sx(b_sx), .sy(b_sy), .de(b_de), .line_start(b_ls), .frame_start(b_fs),
    .frame_count(b_fc), .rgb_in(rgb_in),
    .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
  );

  int tests = 0;
  int fails = 0;

  // reference state: pixel ticks since reset and the colour taken at the last tick
  int k = 0;
  logic [7:0] last_rgb = '0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, k);
    end
  endtask

  // pins after k ticks reflect raster position k-1-lat; negative means still blanked
  function automatic void exp_pins(input int kk, input int lat, input bit hp, input bit vp,
                                   input logic [7:0] rgb, output bit hs, output bit vs,
                                   output int r, output int g, output int b);
    int j;
    int px;
    int py;
    j = kk - 1 - lat;
    hs = !hp; vs = !vp; r = 0; g = 0; b = 0;
    if (j >= 0) begin
      px = j % HT;
      py = (j / HT) % VT;
      if (px >= HA + HF && px < HA + HF + HSW) hs = hp;
      if (py >= VA + VF && py < VA + VF + VSW) vs = vp;
      if (px < HA && py < VA) begin
        r = int'(rgb[7:5]);
        g = int'(rgb[4:2]);
        b = int'(rgb[1:0]);
      end
    end
  endfunction

  task automatic check_model();
    int ex, ey, ef, r, g, b;
    bit ed, els, efs, hs, vs;
    ex  = k % HT;
    ey  = (k / HT) % VT;
    ef  = (k / FT) % (1 << FW);
    ed  = (ex < HA) && (ey < VA);
    els = pix_ce && (ex == 0);
    efs = els && (ey == 0);
    chk("a_sx", int'(a_sx), ex);          chk("b_sx", int'(b_sx), ex);
    chk("a_sy", int'(a_sy), ey);          chk("b_sy", int'(b_sy), ey);
    chk("a_de", int'(a_de), int'(ed));    chk("b_de", int'(b_de), int'(ed));
    chk("a_fc", int'(a_fc), ef);          chk("b_fc", int'(b_fc), ef);
    chk("a_line_start", int'(a_ls), int'(els));
    chk("a_frame_start", int'(a_fs), int'(efs));
    chk("b_frame_start", int'(b_fs), int'(efs));
    exp_pins(k, 0, 1'b0, 1'b0, last_rgb, hs, vs, r, g, b);
    chk("a_hsync", int'(a_hs), int'(hs)); chk("a_vsync", int'(a_vs), int'(vs));
    chk("a_r", int'(a_r), r); chk("a_g", int'(a_g), g); chk("a_b", int'(a_b), b);
    exp_pins(k, 2, 1'b1, 1'b1, last_rgb, hs, vs, r, g, b);
    chk("b_hsync", int'(b_hs), int'(hs)); chk("b_vsync", int'(b_vs), int'(vs));
    chk("b_r", int'(b_r), r); chk("b_g", int'(b_g), g); chk("b_b", int'(b_b), b);
  endtask

  task automatic drive(input bit ce, input logic [7:0] rgb, input bit r);
    @(negedge clk);
    rst = r; pix_ce = ce; rgb_in = rgb;
    #1;
  endtask

  task automatic clock();
    @(posedge clk);
    if (rst) k = 0;
    else if (pix_ce) begin k++; last_rgb = rgb_in; end
    #1;
  endtask

  task automatic step(input bit ce, input logic [7:0] rgb, input bit r);
    drive(ce, rgb, r);
    check_model();
    clock();
  endtask

  task automatic do_reset();
    drive(1'b1, 8'h00, 1'b1);
    clock();
  endtask

  typedef struct {
    int ticks; int sx; int sy; bit de; int fc; bit ls; bit fs; bit hs_a; bit hs_b;
  } vec_t;
  vec_t vt[13];

  initial begin
    int low;
    bit seen;
    //            ticks  sx sy de fc ls fs hsA hsB
    vt[0]  = '{    0,  0, 0, 1, 0, 1, 1, 1, 0};
    vt[1]  = '{    7,  7, 0, 1, 0, 0, 0, 1, 0};
    vt[2]  = '{    8,  8, 0, 0, 0, 0, 0, 1, 0};
    vt[3]  = '{   11, 11, 0, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{   13, 13, 0, 0, 0, 0, 0, 0, 1};
    vt[5]  = '{   14, 14, 0, 0, 0, 0, 0, 1, 1};
    vt[6]  = '{   15,  0, 1, 1, 0, 1, 0, 1, 1};
    vt[7]  = '{   59, 14, 3, 0, 0, 0, 0, 1, 1};
    vt[8]  = '{   60,  0, 4, 0, 0, 1, 0, 1, 1};
    vt[9]  = '{  119, 14, 7, 0, 0, 0, 0, 1, 1};
    vt[10] = '{  120,  0, 0, 1, 1, 1, 1, 1, 1};
    vt[11] = '{  130, 10, 0, 0, 1, 0, 0, 1, 0};
    vt[12] = '{ 1925,  5, 0, 1, 0, 0, 0, 1, 0};

    do_reset();

    // directed positions from reset with pix_ce held high
    for (int v = 0; v < 13; v++) begin
      do_reset();
      for (int n = 0; n < vt[v].ticks; n++) step(1'b1, 8'($urandom), 1'b0);
      drive(1'b1, 8'hFF, 1'b0);
      chk("tbl_sx", int'(a_sx), vt[v].sx);
      chk("tbl_sy", int'(a_sy), vt[v].sy);
      chk("tbl_de", int'(a_de), int'(vt[v].de));
      chk("tbl_fc", int'(a_fc), vt[v].fc);
      chk("tbl_line_start", int'(a_ls), int'(vt[v].ls));
      chk("tbl_frame_start", int'(a_fs), int'(vt[v].fs));
      chk("tbl_hsync_a", int'(a_hs), int'(vt[v].hs_a));
      chk("tbl_hsync_b", int'(b_hs), int'(vt[v].hs_b));
      check_model();
      clock();
    end

    // reset mid-frame with pix_ce high, after frame_count has advanced
    do_reset();
    for (int n = 0; n < 125; n++) step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    drive(1'b1, 8'hFF, 1'b0);
    chk("rst_sx", int'(a_sx), 0);
    chk("rst_sy", int'(a_sy), 0);
    chk("rst_fc", int'(a_fc), 0);
    chk("rst_hsync_a", int'(a_hs), 1);
    chk("rst_vsync_a", int'(a_vs), 1);
    chk("rst_hsync_b", int'(b_hs), 0);
    chk("rst_colour_a", int'({a_r, a_g, a_b}), 0);
    chk("rst_frame_start", int'(a_fs), 1);
    check_model();
    clock();

    // hsync width with pix_ce one cycle in four: 3 ticks -> 12 clocks
    do_reset();
    low = 0; seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      step(c % 4 == 0, 8'($urandom), 1'b0);
      if (a_hs == 1'b0) begin seen = 1'b1; low++; end
      else if (seen) break;
    end
    chk("ce4_hsync_low_clocks", low, HSW * 4);

    // vsync width at full rate: 2 lines -> 30 clocks
    do_reset();
    low = 0; seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step(1'b1, 8'($urandom), 1'b0);
      if (a_vs == 1'b0) begin seen = 1'b1; low++; end
      else if (seen) break;
    end
    chk("vsync_low_clocks", low, VSW * HT);

    // randomized ce, colour and occasional reset against the model
    do_reset();
    for (int c = 0; c < 5000; c++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 599) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
